axi_full_burst_master: RTL and testbench
========================================

Name: axi_full_burst_master

Overview:
- AXI4 full master burst engine; the upstream stage that drives the team's AXI full slave test models over one AXI4 port.
- Accepts single read or write burst commands on a valid/ready command port.
- Writes an incrementing data pattern.
- Checks returned read data against the same pattern.
- Reports completion and error status.

Parameters:
C_M_AXI_ID_WIDTH, 1, ID width; AWID/ARID driven to 0.
C_M_AXI_DATA_WIDTH, 32, data width (multiple of 8).
C_M_AXI_ADDR_WIDTH, 6, address width.
TIMEOUT_CYCLES, 256, watchdog limit (used only with optional feature); must be at least 2.

Ports:
M_AXI_ACLK  in  1  clock
M_AXI_ARESETN  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_WIDTH  burst start address
cmd_len  in  8  beats minus 1 (AXI AxLEN encoding)
done  out  1  one-cycle completion pulse
err_resp  out  1  non-OKAY BRESP/RRESP seen
err_data  out  1  read data mismatch
err_last  out  1  RLAST protocol violation
err_timeout  out  1  watchdog expiry
M_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  out  ID/ADDR/8/3/2  write address
M_AXI_AWVALID  out  1; M_AXI_AWREADY  in  1
M_AXI_WDATA/WSTRB/WLAST/WVALID  out  DATA/DATA/8/1/1; M_AXI_WREADY  in  1
M_AXI_BID/BRESP/BVALID  in  ID/2/1; M_AXI_BREADY  out  1
M_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  out  ID/ADDR/8/3/2  read address
M_AXI_ARVALID  out  1; M_AXI_ARREADY  in  1
M_AXI_RID/RDATA/RRESP/RLAST/RVALID  in  ID/DATA/2/1/1; M_AXI_RREADY  out  1

Behaviour:
- States: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- Reset: state IDLE; all VALID/READY outputs 0; done 0; all err_* 0; beat counter 0.
- IDLE: cmd_ready=1.
  - On cmd_valid, latch addr, len and write flag.
  - Clear all err_* flags.
  - Next state is WR_ADDR if write, else RD_ADDR.
- Address channel constants: AxSIZE = log2(DATA_WIDTH/8); AxBURST = 2'b01 (INCR); AxLEN = latched len. Outputs are stable while VALID is high.
- WR_ADDR: AWVALID=1; on AWREADY go to WR_DATA. W is not issued before the AW handshake completes.
- WR_DATA:
  - WVALID=1; WDATA = beat_cnt+1, zero-extended; WSTRB all ones.
  - WLAST=1 exactly when beat_cnt==len.
  - beat_cnt increments on each W handshake. On the WLAST handshake go to WR_RESP and clear beat_cnt.
- WR_RESP: BREADY=1. On BVALID, set err_resp if BRESP!=0, then go to DONE.
- RD_ADDR: ARVALID=1; on ARREADY go to RD_DATA.
- RD_DATA: RREADY=1. On each R handshake:
  - err_data set if RDATA != beat_cnt+1.
  - err_resp set if RRESP!=0.
  - err_last set if RLAST=1 with beat_cnt<len, or RLAST=0 with beat_cnt==len.
  - Burst ends on an RLAST handshake, or on beat len+256 as a backstop. On end go to DONE.
- DONE: done=1 for one cycle, then IDLE. err_* hold until the next command is accepted.
- Error flags are sticky within a command. Several flags may be set in the same beat.
- cmd_len=0: single beat; WLAST is set on the first beat.
- beat_cnt is 9 bits; data pattern arithmetic wraps modulo 2^DATA_WIDTH.
- Asynchronous reset mid-burst: all VALIDs drop immediately, returns to IDLE, and no done pulse is produced.
- Back-to-back commands: cmd_ready reasserts the cycle after done.

Optional Feature:
- Macro AXI_FULL_MASTER_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in every non-IDLE, non-DONE state.
  - It clears on any AW/W/B/AR/R handshake.
  - When it reaches TIMEOUT_CYCLES: set err_timeout, deassert all VALID/READY next cycle, go to DONE, pulse done.
- Undefined: no counter; err_timeout is tied 0; the port remains.

Test Plan:
- Write cmd addr=0x10 len=3, slave ready always, BRESP=0 -> AWLEN=3, WDATA 1,2,3,4, WLAST on 4th beat, done pulse, all err_*=0.
- Read cmd len=3, slave returns 1,2,3,4 with RLAST on beat 4 -> done, err_data=0, err_last=0.
- Read len=3, slave returns 1,2,7,4 -> err_data=1 after done; the next command clears it.
- Read len=3, slave asserts RLAST on beat 2 -> burst ends, err_last=1, done pulse.
- Write len=0 with WREADY held low for 5 cycles, then BRESP=2'b10 -> WVALID held with WDATA=1 throughout, err_resp=1.
- With TIMEOUT_EN and TIMEOUT_CYCLES=16, read with ARREADY never high -> ARVALID drops after 16 cycles, err_timeout=1, done pulse. Reset asserted mid-burst -> outputs return to reset values immediately.

Source files
------------

// File: rtl/axi_full_burst_master.sv
// AXI4 full burst master: single INCR read/write bursts with an incrementing data pattern.
// Optional watchdog enabled by defining AXI_FULL_MASTER_TIMEOUT_EN.

module axi_full_burst_master #(
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 6,
    parameter int TIMEOUT_CYCLES     = 256
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]                      cmd_len,
    output logic                            done,
    output logic                            err_resp,
    output logic                            err_data,
    output logic                            err_last,
    output logic                            err_timeout,
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic [2:0]                      M_AXI_ARSIZE,
    output logic [1:0]                      M_AXI_ARBURST,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RLAST,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int         PAT_W  = (C_M_AXI_DATA_WIDTH > 9) ? C_M_AXI_DATA_WIDTH : 9;
    localparam logic [2:0] AXSIZE = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
    } state_t;

    state_t                          state;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]                      len_q;
    logic [8:0]                      beat_cnt;
    logic [8:0]                      len_ext;
    logic                            last_beat;
    logic [PAT_W-1:0]                pattern_ext;
    logic [C_M_AXI_DATA_WIDTH-1:0]   pattern;
    logic                            aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                            unused_ok;

    // Pattern is computed wide enough to hold beat_cnt, then wraps to the data width.
    assign pattern_ext = PAT_W'(beat_cnt) + PAT_W'(1);
    assign pattern     = pattern_ext[C_M_AXI_DATA_WIDTH-1:0];
    assign len_ext     = {1'b0, len_q};
    assign last_beat   = (beat_cnt == len_ext);

    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID  && M_AXI_WREADY;
    assign b_hs  = M_AXI_BVALID  && M_AXI_BREADY;
    assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_hs  = M_AXI_RVALID  && M_AXI_RREADY;

    assign cmd_ready     = (state == IDLE);
    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWLEN   = len_q;
    assign M_AXI_AWSIZE  = AXSIZE;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARLEN   = len_q;
    assign M_AXI_ARSIZE  = AXSIZE;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_WDATA   = pattern;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = M_AXI_WVALID && last_beat;

    assign unused_ok = ^{M_AXI_BID, M_AXI_RID, pattern_ext, TIMEOUT_CYCLES[0]};

`ifdef AXI_FULL_MASTER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            err_timeout_q;
    logic            hs_any;
    assign hs_any      = aw_hs || w_hs || b_hs || ar_hs || r_hs;
    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state         <= IDLE;
            addr_q        <= '0;
            len_q         <= '0;
            beat_cnt      <= '0;
            done          <= 1'b0;
            err_resp      <= 1'b0;
            err_data      <= 1'b0;
            err_last      <= 1'b0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
`ifdef AXI_FULL_MASTER_TIMEOUT_EN
            wd_cnt        <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q   <= cmd_addr;
                        len_q    <= cmd_len;
                        beat_cnt <= '0;
                        err_resp <= 1'b0;
                        err_data <= 1'b0;
                        err_last <= 1'b0;
                        if (cmd_write) begin
                            state         <= WR_ADDR;
                            M_AXI_AWVALID <= 1'b1;
                        end else begin
                            state         <= RD_ADDR;
                            M_AXI_ARVALID <= 1'b1;
                        end
                    end
                end
                WR_ADDR: begin
                    if (aw_hs) begin
                        M_AXI_AWVALID <= 1'b0;
                        M_AXI_WVALID  <= 1'b1;
                        state         <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        if (last_beat) begin
                            beat_cnt     <= '0;
                            M_AXI_WVALID <= 1'b0;
                            M_AXI_BREADY <= 1'b1;
                            state        <= WR_RESP;
                        end else begin
                            beat_cnt <= beat_cnt + 9'd1;
                        end
                    end
                end
                WR_RESP: begin
                    if (b_hs) begin
                        if (M_AXI_BRESP != 2'b00) err_resp <= 1'b1;
                        M_AXI_BREADY <= 1'b0;
                        done         <= 1'b1;
                        state        <= DONE;
                    end
                end
                RD_ADDR: begin
                    if (ar_hs) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (r_hs) begin
                        if (M_AXI_RDATA != pattern) err_data <= 1'b1;
                        if (M_AXI_RRESP != 2'b00) err_resp <= 1'b1;
                        if ((M_AXI_RLAST && (beat_cnt < len_ext)) || (!M_AXI_RLAST && last_beat))
                            err_last <= 1'b1;
                        // A slave that never raises RLAST is cut off 256 beats past the request.
                        if (M_AXI_RLAST || (beat_cnt == len_ext + 9'd256)) begin
                            beat_cnt     <= '0;
                            M_AXI_RREADY <= 1'b0;
                            done         <= 1'b1;
                            state        <= DONE;
                        end else begin
                            beat_cnt <= beat_cnt + 9'd1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
`ifdef AXI_FULL_MASTER_TIMEOUT_EN
            if (state == IDLE && cmd_valid) err_timeout_q <= 1'b0;
            // Watchdog overrides the normal transition when a channel stalls too long.
            if (state != IDLE && state != DONE) begin
                if (hs_any) begin
                    wd_cnt <= '0;
                end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    wd_cnt        <= '0;
                    err_timeout_q <= 1'b1;
                    beat_cnt      <= '0;
                    M_AXI_AWVALID <= 1'b0;
                    M_AXI_WVALID  <= 1'b0;
                    M_AXI_BREADY  <= 1'b0;
                    M_AXI_ARVALID <= 1'b0;
                    M_AXI_RREADY  <= 1'b0;
                    done          <= 1'b1;
                    state         <= DONE;
                end else begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                end
            end else begin
                wd_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_axi_full_burst_master.sv
// Directed bench for axi_full_burst_master: the bench plays the AXI slave and scores
// write data and completion status against queues filled when each command is issued.

module tb_axi_full_burst_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [5:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic        done, err_resp, err_data, err_last, err_timeout;
    logic [0:0]  awid, bid, arid, rid;
    logic [5:0]  awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;

    int tests = 0;
    int fails = 0;
    logic [31:0] wq[$];
    logic [3:0]  sq[$];

    always #5 clk = ~clk;

    axi_full_burst_master #(
        .C_M_AXI_ID_WIDTH(1), .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_ADDR_WIDTH(6), .TIMEOUT_CYCLES(TO)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .done(done),
        .err_resp(err_resp), .err_data(err_data), .err_last(err_last), .err_timeout(err_timeout),
        .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_vec();
        return {28'd0, err_resp, err_data, err_last, err_timeout};
    endfunction

    function automatic logic [31:0] valids_vec();
        return {26'd0, awvalid, wvalid, bready, arvalid, rready, done};
    endfunction

    // Presents a command and returns at the falling edge after it was accepted.
    task automatic apply_stimulus(input logic wr, input logic [5:0] addr, input logic [7:0] len);
        int guard = 0;
        @(negedge clk);
        awready = 1'b0; arready = 1'b0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_output("cmd_accept", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_output("err_cleared", status_vec(), 32'd0);
    endtask

    task automatic finish_cmd(input string tag, input bit fin);
        check_output({tag, "_finished"}, 32'(fin), 32'd1);
        check_output({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check_output({tag, "_ready_after_done"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic run_write(input logic [5:0] addr, input logic [7:0] len, input int wstall,
                             input logic [1:0] bresp_v, input logic [3:0] exp_st);
        int beat = 0, stall = 0, guard = 0;
        bit aw_seen = 0, b_pend = 0, fin = 0;
        logic [31:0] exp;
        for (int i = 0; i <= int'(len); i++) wq.push_back(32'(i + 1));
        sq.push_back(exp_st);
        apply_stimulus(1'b1, addr, len);
        while (!fin && guard < 100) begin
            awready = 1'b1;
            wready  = (stall >= wstall);
            bvalid  = b_pend;
            bresp   = b_pend ? bresp_v : 2'b00;
            if (wvalid && !aw_seen) check_output("w_before_aw", 32'(wvalid), 32'd0);
            if (awvalid) begin
                check_output("awaddr", 32'(awaddr), 32'(addr));
                check_output("awlen", 32'(awlen), 32'(len));
                check_output("awsize_burst_id", {27'd0, awsize, awburst} | 32'(awid), 32'h09);
                aw_seen = 1;
            end
            if (wvalid) begin
                exp = (wq.size() > 0) ? wq[0] : 32'hdead_beef;
                if (!wready) begin
                    check_output("wdata_hold", wdata, exp);
                    stall++;
                end else begin
                    if (wq.size() > 0) void'(wq.pop_front());
                    check_output("wdata", wdata, exp);
                    check_output("wlast", 32'(wlast), 32'(beat == int'(len)));
                    check_output("wstrb", 32'(wstrb), 32'hf);
                    if (beat == int'(len)) b_pend = 1;
                    beat++;
                end
            end
            if (bvalid && bready) b_pend = 0;
            if (done) begin
                check_output("write_status", status_vec(), 32'(sq.pop_front()));
                fin = 1;
            end
            @(negedge clk);
            guard++;
        end
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        finish_cmd("write", fin);
    endtask

    task automatic run_read(input logic [5:0] addr, input logic [7:0] len, input logic [127:0] rd,
                            input int last_at, input logic [1:0] rresp_v, input logic [3:0] exp_st);
        int beat = 0, guard = 0;
        bit r_go = 0, r_end = 0, fin = 0;
        sq.push_back(exp_st);
        apply_stimulus(1'b0, addr, len);
        while (!fin && guard < 100) begin
            arready = 1'b1;
            if (r_go && !r_end && beat < 4) begin
                rvalid = 1'b1;
                rdata  = rd[32*beat +: 32];
                rlast  = (beat == last_at);
                rresp  = rresp_v;
            end else begin
                rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
            end
            if (rvalid && rready) begin
                if (rlast) r_end = 1;
                beat++;
            end
            if (arvalid) begin
                check_output("araddr", 32'(araddr), 32'(addr));
                check_output("arlen", 32'(arlen), 32'(len));
                check_output("arsize_burst_id", {27'd0, arsize, arburst} | 32'(arid), 32'h09);
                r_go = 1;
            end
            if (done) begin
                check_output("read_status", status_vec(), 32'(sq.pop_front()));
                fin = 1;
            end
            @(negedge clk);
            guard++;
        end
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        finish_cmd("read", fin);
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = '0;

        #1;
        check_output("reset_outputs", valids_vec(), 32'd0);
        check_output("reset_errors", status_vec(), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Plain write burst, then a clean read of the same pattern.
        run_write(6'h10, 8'd3, 0, 2'b00, 4'b0000);
        run_read(6'h10, 8'd3, {32'd4, 32'd3, 32'd2, 32'd1}, 3, 2'b00, 4'b0000);

        // Corrupted third beat: error must hold after done until the next command.
        run_read(6'h20, 8'd3, {32'd4, 32'd7, 32'd2, 32'd1}, 3, 2'b00, 4'b0100);
        @(negedge clk);
        check_output("err_data_held", 32'(err_data), 32'd1);

        // Early RLAST on beat 2 ends the burst with a protocol error.
        run_read(6'h04, 8'd3, {32'd0, 32'd0, 32'd2, 32'd1}, 1, 2'b00, 4'b0010);

        // Single beat write with WREADY stalled and a SLVERR response.
        run_write(6'h08, 8'd0, 5, 2'b10, 4'b1000);

        // Slave error and bad data on the same beat, single-beat burst.
        run_read(6'h3c, 8'd0, {32'd0, 32'd0, 32'd0, 32'd9}, 0, 2'b10, 4'b1100);

        // Back-to-back commands straight after the previous done.
        run_write(6'h00, 8'd1, 0, 2'b00, 4'b0000);

`ifdef AXI_FULL_MASTER_TIMEOUT_EN
        begin
            int hi = 0, guard = 0;
            bit fin = 0;
            sq.push_back(4'b0001);
            apply_stimulus(1'b0, 6'h18, 8'd3);
            while (!fin && guard < 100) begin
                if (arvalid) hi++;
                if (done) begin
                    check_output("timeout_status", status_vec(), 32'(sq.pop_front()));
                    check_output("timeout_arvalid_low", 32'(arvalid), 32'd0);
                    fin = 1;
                end
                @(negedge clk);
                guard++;
            end
            check_output("timeout_arvalid_cycles", 32'(hi), 32'(TO));
            finish_cmd("timeout", fin);
        end
`endif

        // Asynchronous reset in the middle of a stalled write burst.
        apply_stimulus(1'b1, 6'h2c, 8'd3);
        awready = 1'b1;
        wready  = 1'b0;
        @(negedge clk);
        awready = 1'b0;
        @(negedge clk);
        check_output("wvalid_before_reset", 32'(wvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_output("reset_mid_burst_outputs", valids_vec(), 32'd0);
        check_output("reset_mid_burst_errors", status_vec(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            bit saw_done = 0;
            for (int i = 0; i < 5; i++) begin
                if (done) saw_done = 1;
                @(negedge clk);
            end
            check_output("no_done_after_reset", 32'(saw_done), 32'd0);
        end
        check_output("ready_after_reset", 32'(cmd_ready), 32'd1);

        check_output("wq_empty", 32'(wq.size()), 32'd0);
        check_output("sq_empty", 32'(sq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
